diffeq_result_serializer: RTL and testbench
===========================================

// Module: diffeq_result_serializer
// PURPOSE
//  Output-side counterpart of the differential-equation datapath's 4-bit serial operand loader.
//  Captures each final 16-bit result y when the solver loop terminates.
//  Queues results in a small FIFO and streams each one out as NIBS = DATA_W/NIB_W nibbles,
//  MSB-first, over a valid/ready nibble bus. Sits between the datapath/controller and the host.
// PARAMETERS
//  DATA_W  16  result width; must be an integer multiple of NIB_W
//  NIB_W   4   width of the serial output bus (matches the input nibble bus)
//  DEPTH   2   result FIFO entries (>=1)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset      in   1       asynchronous, active-high
//  res_valid  in   1       one-cycle strobe: loop finished (compute_done & ~continue_while)
//  res_data   in   DATA_W  final y, sampled when res_valid=1
//  res_ready  out  1       FIFO not full (count < DEPTH), driven from registered count only
//  nib_out    out  NIB_W   current nibble
//  nib_valid  out  1       nib_out is valid
//  nib_ready  in   1       host accepts nib_out on a rising edge with nib_valid=1
//  nib_first  out  1       high with nibble 0 of a result
//  nib_last   out  1       high with nibble NIBS-1 of a result
//  busy       out  1       FSM in SEND or FIFO non-empty
//  overflow   out  1       sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (any time, including mid-frame)
//    - FIFO is emptied and the FSM goes to IDLE.
//    - nib_out=0, nib_valid=0, nib_first=0, nib_last=0, busy=0, overflow=0; res_ready=1.
//    - An aborted frame is never resumed.
//  - Push
//    - On an edge with res_valid=1 and res_ready=1, res_data is written at the FIFO tail.
//    - If res_valid=1 and res_ready=0, the result is dropped and overflow is set.
//    - overflow is cleared only by reset.
//    - res_ready is evaluated before any same-cycle pop, so a full FIFO refuses a push
//      even in a cycle where it pops.
//  - FSM states: IDLE, SEND
//    - IDLE: if the FIFO is non-empty, load the shift register from the FIFO head, pop,
//      set idx=0, go to SEND.
//    - SEND: nib_valid=1 and nib_out = sreg[DATA_W-1 -: NIB_W].
//      - nib_first = (idx==0); nib_last = (idx==NIBS-1).
//      - On handshake: shift sreg left by NIB_W and increment idx.
//      - Handshake with idx==NIBS-1 and FIFO non-empty: reload from the head, pop, idx=0,
//        stay in SEND. No bubble between frames.
//      - Handshake with idx==NIBS-1 and FIFO empty: go to IDLE; nib_valid=0 next cycle.
//  - Bus stability: while nib_valid=1 and nib_ready=0, nib_out, nib_first and nib_last
//    hold constant. nib_valid never drops without a handshake except on reset.
//  - Latency: with the FIFO empty and the FSM in IDLE, a push on edge k gives nib_valid=1
//    after edge k+1 (first nibble). A frame takes NIBS handshakes minimum.
//  - Simultaneous push and pop: allowed when count<DEPTH; count stays unchanged.
//  - Widths: idx is $clog2(NIBS) bits (min 1); count is $clog2(DEPTH+1) bits.
//    FIFO pointers wrap modulo DEPTH.
// STRUCTURE
//  - diffeq_pkg holds:
//    - FSM state encodings (S_TX_IDLE, S_TX_SEND);
//    - DATA_W/NIB_W defaults;
//    - shared datapath state localparams (S_IDLE..S_DONE) for the controller link.
//  - One sub-module, diffeq_result_fifo:
//    - parameterised DATA_W and DEPTH, circular buffer;
//    - ports push, pop, din, dout, count, full, empty; async reset.
//  - The top level contains the FSM, the shift register, idx, and the overflow flag.
// TESTING
//  - Single result: push 16'h1A2B on edge k, nib_ready=1
//    -> nib_valid from edge k+1; nibbles 1, A, 2, B on consecutive cycles;
//       nib_first only on 1, nib_last only on B; then nib_valid=0 and busy=0.
//  - Backpressure: push 16'h1A2B, drop nib_ready for 3 cycles when nibble 2 is presented
//    -> nib_out=2 with nib_first=nib_last=0 for all 3 cycles; then 2, B are accepted.
//  - Back-to-back: push 16'h1234 and 16'hABCD on consecutive edges, nib_ready=1
//    -> 8 nibbles 1,2,3,4,A,B,C,D with no gap; nib_last on 4 and on D.
//  - Overflow: DEPTH=2, nib_ready=0, push 16'h0001, 16'h0002, 16'h0003 on consecutive edges
//    -> the first loads into sreg; the FIFO then holds 2 and 3; res_ready=0; overflow=0.
//    A further push of 16'h0004 -> overflow=1, and the dropped value is never emitted.
//  - Reset mid-frame: push 16'hBEEF, accept nibbles B and E, then assert reset
//    -> all outputs return to reset values.
//    Then push 16'h0F0F -> fresh frame 0, F, 0, F with nib_first on the first 0.
//  - Flush: after reset with no pushes, hold nib_ready=1 for 10 cycles
//    -> nib_valid stays 0 and res_ready stays 1.

Source files
------------

// File: rtl/diffeq_pkg.sv
// diffeq_pkg: shared widths, serializer FSM encoding and datapath controller states
package diffeq_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int NIB_W_DEF  = 4;
    typedef enum logic {S_TX_IDLE, S_TX_SEND} tx_state_e;
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_CALC = 2'd2, S_DONE = 2'd3;
endpackage

// File: rtl/diffeq_result_serializer_if.sv
// diffeq_result_serializer_if: result capture port plus serial nibble bus toward the host
interface diffeq_result_serializer_if #(
    parameter int DATA_W = diffeq_pkg::DATA_W_DEF,
    parameter int NIB_W  = diffeq_pkg::NIB_W_DEF
);
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [NIB_W-1:0]  nib_out;
    logic              nib_valid;
    logic              nib_ready;
    logic              nib_first;
    logic              nib_last;
    logic              busy;
    logic              overflow;
    modport slave (
        input  res_valid, res_data, nib_ready,
        output res_ready, nib_out, nib_valid, nib_first, nib_last, busy, overflow
    );
    modport master (
        output res_valid, res_data, nib_ready,
        input  res_ready, nib_out, nib_valid, nib_first, nib_last, busy, overflow
    );
endinterface

// File: rtl/diffeq_result_fifo.sv
// diffeq_result_fifo: circular result buffer; caller must not push when full or pop when empty
module diffeq_result_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = din;
        wptr_d  = push ? nxt(wptr_q) : wptr_q;
        rptr_d  = pop ? nxt(rptr_q) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end

    always_ff @(posedge clk)
        mem_q <= mem_d;

    assign dout  = mem_q[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/diffeq_result_serializer.sv
// diffeq_result_serializer: queues final y results and streams each out MSB-first as nibbles
module diffeq_result_serializer
    import diffeq_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NIB_W  = NIB_W_DEF,
    parameter  int DEPTH  = 2,
    localparam int NIBS   = DATA_W / NIB_W,
    localparam int IW     = (NIBS > 1) ? $clog2(NIBS) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic reset,
    diffeq_result_serializer_if.slave bus
);
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     fifo_count;
    logic              full, empty, push, pop, sending, hs, last;

    // res_ready comes from the registered count so a full FIFO refuses even while popping
    assign bus.res_ready = (fifo_count < CW'(DEPTH));
    assign push          = bus.res_valid & ~full;
    assign sending       = (state_q == S_TX_SEND);
    assign hs            = sending & bus.nib_ready;
    assign last          = (idx_q == IW'(NIBS - 1));

    diffeq_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(bus.res_data),
        .dout(head), .count(fifo_count), .full(full), .empty(empty)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (bus.res_valid & ~bus.res_ready);
        if ((!sending || (hs && last)) && !empty) begin
            state_d = S_TX_SEND;
            sreg_d  = head;
            idx_d   = '0;
            pop     = 1'b1;
        end else if (hs && last) begin
            state_d = S_TX_IDLE;
        end else if (hs) begin
            sreg_d = sreg_q << NIB_W;
            idx_d  = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= S_TX_IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end

    assign bus.nib_valid = sending;
    assign bus.nib_out   = sending ? sreg_q[DATA_W-1 -: NIB_W] : '0;
    assign bus.nib_first = sending & (idx_q == '0);
    assign bus.nib_last  = sending & last;
    assign bus.busy      = sending | ~empty;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_diffeq_result_serializer.sv
// tb_diffeq_result_serializer: directed scenario tasks with hand-computed nibble streams
module tb_diffeq_result_serializer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    diffeq_result_serializer_if #(.DATA_W(16), .NIB_W(4)) bus ();
    diffeq_result_serializer #(.DATA_W(16), .NIB_W(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        bus.res_valid = 1'b0;
        bus.nib_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [15:0] v);
        bus.res_valid = 1'b1;
        bus.res_data  = v;
        step();
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.nib_ready = 1'b0;
        #3;
        tests++;
        if ({bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready} !== 10'b0000_000001) begin
            failed++;
            $display("FAIL reset_async got %b want 0000000001", {bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready});
        end
        step();
        step();
        reset = 1'b0;
        step();
        tests++;
        if ({bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready} !== 10'b0000_000001) begin
            failed++;
            $display("FAIL reset_idle got %b want 0000000001", {bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready});
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_n [4] = '{4'h1, 4'hA, 4'h2, 4'hB};
        apply_reset();
        bus.nib_ready = 1'b1;
        push_one(16'h1A2B);
        tests++;
        if (bus.nib_valid !== 1'b0) begin
            failed++;
            $display("FAIL single_latency nib_valid got %b want 0", bus.nib_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid} !== {exp_n[i], i == 0, i == 3, 1'b1}) begin
                failed++;
                $display("FAIL single_nib%0d got %h/%b%b%b want %h/%b%b1", i, bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid, exp_n[i], i == 0, i == 3);
            end
        end
        step();
        tests++;
        if ({bus.nib_valid, bus.busy} !== 2'b00) begin
            failed++;
            $display("FAIL single_end valid,busy got %b%b want 00", bus.nib_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        apply_reset();
        bus.nib_ready = 1'b1;
        push_one(16'h1A2B);
        step();
        step();
        step();
        bus.nib_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid} !== {4'h2, 3'b001}) begin
                failed++;
                $display("FAIL bp_hold%0d got %h/%b%b%b want 2/001", c, bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid);
            end
            step();
        end
        bus.nib_ready = 1'b1;
        step();
        tests++;
        if ({bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid} !== {4'hB, 3'b011}) begin
            failed++;
            $display("FAIL bp_last got %h/%b%b%b want B/011", bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid);
        end
        step();
        tests++;
        if (bus.nib_valid !== 1'b0) begin
            failed++;
            $display("FAIL bp_end nib_valid got %b want 0", bus.nib_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_n [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
        apply_reset();
        bus.nib_ready = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = 16'h1234;
        step();
        bus.res_data  = 16'hABCD;
        step();
        bus.res_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid} !== {exp_n[i], i % 4 == 0, i % 4 == 3, 1'b1}) begin
                failed++;
                $display("FAIL b2b_nib%0d got %h/%b%b%b want %h/%b%b1", i, bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid, exp_n[i], i % 4 == 0, i % 4 == 3);
            end
            step();
        end
        tests++;
        if ({bus.nib_valid, bus.busy} !== 2'b00) begin
            failed++;
            $display("FAIL b2b_end valid,busy got %b%b want 00", bus.nib_valid, bus.busy);
        end
    endtask

    task automatic test_overflow;
        logic [3:0] exp_v;
        apply_reset();
        bus.nib_ready = 1'b0;
        bus.res_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            bus.res_data = 16'(v);
            step();
        end
        bus.res_valid = 1'b0;
        tests++;
        if ({bus.res_ready, bus.overflow, bus.nib_valid, bus.busy} !== 4'b0011) begin
            failed++;
            $display("FAIL ovf_full ready,ovf,valid,busy got %b%b%b%b want 0011", bus.res_ready, bus.overflow, bus.nib_valid, bus.busy);
        end
        push_one(16'h0004);
        tests++;
        if (bus.overflow !== 1'b1) begin
            failed++;
            $display("FAIL ovf_set overflow got %b want 1", bus.overflow);
        end
        bus.nib_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_v = (i % 4 == 3) ? 4'(i / 4 + 1) : 4'h0;
            tests++;
            if ({bus.nib_out, bus.nib_valid} !== {exp_v, 1'b1}) begin
                failed++;
                $display("FAIL ovf_nib%0d got %h/%b want %h/1", i, bus.nib_out, bus.nib_valid, exp_v);
            end
            step();
        end
        tests++;
        if ({bus.nib_valid, bus.busy, bus.overflow, bus.res_ready} !== 4'b0011) begin
            failed++;
            $display("FAIL ovf_drained valid,busy,ovf,ready got %b%b%b%b want 0011", bus.nib_valid, bus.busy, bus.overflow, bus.res_ready);
        end
    endtask

    task automatic test_reset_midframe;
        logic [3:0] exp_n [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
        apply_reset();
        bus.nib_ready = 1'b1;
        push_one(16'hBEEF);
        step();
        step();
        step();
        tests++;
        if ({bus.nib_out, bus.nib_valid} !== {4'hE, 1'b1}) begin
            failed++;
            $display("FAIL mid_pre got %h/%b want E/1", bus.nib_out, bus.nib_valid);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready} !== 10'b0000_000001) begin
            failed++;
            $display("FAIL mid_reset got %b want 0000000001", {bus.nib_out, bus.nib_valid, bus.nib_first, bus.nib_last, bus.busy, bus.overflow, bus.res_ready});
        end
        step();
        reset = 1'b0;
        push_one(16'h0F0F);
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid} !== {exp_n[i], i == 0, i == 3, 1'b1}) begin
                failed++;
                $display("FAIL mid_nib%0d got %h/%b%b%b want %h/%b%b1", i, bus.nib_out, bus.nib_first, bus.nib_last, bus.nib_valid, exp_n[i], i == 0, i == 3);
            end
        end
        step();
        tests++;
        if (bus.nib_valid !== 1'b0) begin
            failed++;
            $display("FAIL mid_end nib_valid got %b want 0", bus.nib_valid);
        end
    endtask

    task automatic test_flush;
        apply_reset();
        bus.nib_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            tests++;
            if ({bus.nib_valid, bus.res_ready} !== 2'b01) begin
                failed++;
                $display("FAIL flush%0d valid,ready got %b%b want 01", c, bus.nib_valid, bus.res_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
